writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 70 +++++++
 rtl/writeback_arbiter.sv | 135 +++++++++++++
 tb/tb_writeback_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths, limits and the FIFO entry type for the writeback arbiter.
package wb_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int DATA_W        = 32;
  localparam int WB_FIFO_DEPTH = 4;
  localparam int STARVE_LIMIT  = 8;
  localparam int PTR_W         = 2;
  localparam int CNT_W         = 3;
  localparam int STARVE_W      = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_num;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // One-hot mask of a register number, used to set/clear scoreboard bits.
  function automatic logic [DATA_W-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
    logic [DATA_W-1:0] one;
    one = {{(DATA_W-1){1'b0}}, 1'b1};
    return one << r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Four-entry in-order FIFO for long-latency writeback results.
module wb_fifo
  import wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        wr_entry,
  output wb_entry_t        rd_entry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem_r [WB_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Flags come straight from the count register so a pop never opens room for a same-cycle push.
  assign full     = (count_r == CNT_W'(WB_FIFO_DEPTH));
  assign empty    = (count_r == 3'd0);
  assign count    = count_r;
  assign rd_entry = mem_r[rd_ptr_r];

  // Qualify requests against the current occupancy.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (push && !full) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    if (pop && !empty) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= wr_ptr_r + 2'd1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback arbiter: ALU results take priority, buffered
// long-latency results drain when the port is free or the ALU has starved them too long.
module writeback_arbiter
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_stall,
  input  logic                  lng_valid,
  output logic                  lng_ready,
  input  logic [REG_ADDR_W-1:0] lng_reg,
  input  logic [DATA_W-1:0]     lng_data,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_reg,
  output logic [DATA_W-1:0]     busy,
  output logic                  WE,
  output logic [REG_ADDR_W-1:0] write_reg_number,
  output logic [DATA_W-1:0]     write_data
);

  wb_entry_t             head_s;
  wb_entry_t             push_entry_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic                  alu_win_s;
  logic                  pop_s;
  logic                  push_s;
  logic [DATA_W-1:0]     busy_next_s;
  logic [STARVE_W-1:0]   starve_r;
  logic [DATA_W-1:0]     busy_r;
  logic                  we_r;
  logic [REG_ADDR_W-1:0] wreg_r;
  logic [DATA_W-1:0]     wdata_r;

  assign push_entry_s     = '{reg_num: lng_reg, data: lng_data};
  assign alu_stall        = (starve_r == STARVE_W'(STARVE_LIMIT));
  assign lng_ready        = ~fifo_full_s;
  assign busy             = busy_r;
  assign WE               = we_r;
  assign write_reg_number = wreg_r;
  assign write_data       = wdata_r;

  wb_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .pop      (pop_s),
    .wr_entry (push_entry_s),
    .rd_entry (head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  // Write-port arbitration; r0 results are absorbed without using the port.
  always_comb begin
    alu_win_s = 1'b0;
    pop_s     = 1'b0;
    push_s    = 1'b0;
    if (alu_valid && (alu_reg != 5'd0) && !alu_stall) begin
      alu_win_s = 1'b1;
    end else begin
      alu_win_s = 1'b0;
    end
    if (!alu_win_s && (fifo_count_s != 3'd0)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (lng_valid && !fifo_full_s && (lng_reg != 5'd0)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Scoreboard next state: a reservation overrides a same-cycle clear.
  always_comb begin
    busy_next_s = busy_r;
    if (pop_s) begin
      busy_next_s = busy_next_s & ~reg_mask(head_s.reg_num);
    end else begin
      busy_next_s = busy_r;
    end
    if (rsv_valid && (rsv_reg != 5'd0)) begin
      busy_next_s = busy_next_s | reg_mask(rsv_reg);
    end else begin
      busy_next_s = busy_next_s;
    end
    busy_next_s[0] = 1'b0;
  end

  // Starvation counter and pending-write scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r <= 4'd0;
      busy_r   <= 32'd0;
    end else begin
      busy_r <= busy_next_s;
      if (fifo_empty_s || pop_s) begin
        starve_r <= 4'd0;
      end else if (alu_win_s && !alu_stall) begin
        starve_r <= starve_r + 4'd1;
      end else begin
        starve_r <= starve_r;
      end
    end
  end

  // Registered write port; address and data hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      wreg_r  <= 5'd0;
      wdata_r <= 32'd0;
    end else if (alu_win_s) begin
      we_r    <= 1'b1;
      wreg_r  <= alu_reg;
      wdata_r <= alu_data;
    end else if (pop_s) begin
      we_r    <= 1'b1;
      wreg_r  <= head_s.reg_num;
      wdata_r <= head_s.data;
    end else begin
      we_r    <= 1'b0;
      wreg_r  <= wreg_r;
      wdata_r <= wdata_r;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; ALU results carry data bit 31 set, long-latency
// results carry it clear, so each write is matched against its own source queue.
module tb_writeback_arbiter;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lng_valid;
  logic        lng_ready;
  logic [4:0]  lng_reg;
  logic [31:0] lng_data;
  logic        rsv_valid;
  logic [4:0]  rsv_reg;
  logic [31:0] busy;
  logic        we;
  logic [4:0]  write_reg_number;
  logic [31:0] write_data;

  exp_t alu_q[$];
  exp_t lng_q[$];
  int   checks;
  int   errors;

  writeback_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_valid        (alu_valid),
    .alu_reg          (alu_reg),
    .alu_data         (alu_data),
    .alu_stall        (alu_stall),
    .lng_valid        (lng_valid),
    .lng_ready        (lng_ready),
    .lng_reg          (lng_reg),
    .lng_data         (lng_data),
    .rsv_valid        (rsv_valid),
    .rsv_reg          (rsv_reg),
    .busy             (busy),
    .WE               (we),
    .write_reg_number (write_reg_number),
    .write_data       (write_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
    lng_valid = 1'b0; lng_reg = 5'd0; lng_data = 32'd0;
    rsv_valid = 1'b0; rsv_reg = 5'd0;
  endtask

  // Advance one clock and score any write that appeared.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (we === 1'b1) begin
      if (write_data[31]) begin
        checks++;
        assert (alu_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_alu_write observed=%0d/%h expected=none", write_reg_number, write_data);
        end
        if (alu_q.size() != 0) begin
          e = alu_q.pop_front();
          chk("alu_wr_reg", 32'(write_reg_number), 32'(e.r));
          chk("alu_wr_data", write_data, e.d);
        end
      end else begin
        checks++;
        assert (lng_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_lng_write observed=%0d/%h expected=none", write_reg_number, write_data);
        end
        if (lng_q.size() != 0) begin
          e = lng_q.pop_front();
          chk("lng_wr_reg", 32'(write_reg_number), 32'(e.r));
          chk("lng_wr_data", write_data, e.d);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'($urandom); alu_reg = 5'($urandom); alu_data = $urandom;
      lng_valid = 1'($urandom); lng_reg = 5'($urandom); lng_data = $urandom;
      rsv_valid = 1'($urandom); rsv_reg = 5'($urandom);
      tick();
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_lng_ready", 32'(lng_ready), 32'd1);
      chk("rst_alu_stall", 32'(alu_stall), 32'd0);
    end
    chk("rst_wreg", 32'(write_reg_number), 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    tick();
    chk("post_rst_we", 32'(we), 32'd0);

    // ALU only: one-cycle write, then r0 is swallowed
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    alu_q.push_back('{r: 5'd5, d: 32'hDEADBEEF});
    tick();
    chk("alu_we_n1", 32'(we), 32'd1);
    alu_valid = 1'b0;
    tick();
    chk("alu_we_n2", 32'(we), 32'd0);
    chk("alu_hold_reg", 32'(write_reg_number), 32'd5);
    chk("alu_hold_data", write_data, 32'hDEADBEEF);
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFFFFFF;
    tick();
    chk("alu_r0_we", 32'(we), 32'd0);
    alu_valid = 1'b0;
    tick();
    chk("alu_r0_we2", 32'(we), 32'd0);

    // Scoreboard around a reserved long-latency write
    rsv_valid = 1'b1; rsv_reg = 5'd9;
    tick();
    rsv_valid = 1'b0;
    chk("busy9_set", 32'(busy[9]), 32'd1);
    chk("sb_lng_ready", 32'(lng_ready), 32'd1);
    lng_valid = 1'b1; lng_reg = 5'd9; lng_data = 32'h00001234;
    lng_q.push_back('{r: 5'd9, d: 32'h00001234});
    tick();
    lng_valid = 1'b0;
    chk("busy9_queued", 32'(busy[9]), 32'd1);
    chk("sb_no_we_yet", 32'(we), 32'd0);
    tick();
    chk("sb_pop_we", 32'(we), 32'd1);
    chk("busy9_clear", 32'(busy[9]), 32'd0);
    tick();
    chk("sb_we_done", 32'(we), 32'd0);

    // Full FIFO under continuous ALU pressure
    alu_valid = 1'b1; alu_reg = 5'd20;
    for (int i = 0; i < 9; i++) begin
      alu_data = 32'h80000000 | 32'(i);
      alu_q.push_back('{r: 5'd20, d: alu_data});
      lng_valid = 1'b1;
      if (i < 4) begin
        lng_reg = 5'(i + 1); lng_data = 32'h100 + 32'(i + 1);
        chk("full_ready_open", 32'(lng_ready), 32'd1);
        lng_q.push_back('{r: lng_reg, d: lng_data});
      end else begin
        lng_reg = 5'd5; lng_data = 32'h105;
        chk("full_ready_low", 32'(lng_ready), 32'd0);
      end
      chk("full_no_stall", 32'(alu_stall), 32'd0);
      tick();
    end
    chk("full_stall_high", 32'(alu_stall), 32'd1);
    chk("full_ready_still_low", 32'(lng_ready), 32'd0);
    alu_data = 32'h80000009;
    tick();
    chk("full_first_pop_reg", 32'(write_reg_number), 32'd1);
    chk("full_stall_cleared", 32'(alu_stall), 32'd0);
    chk("full_ready_reopen", 32'(lng_ready), 32'd1);
    lng_q.push_back('{r: 5'd5, d: 32'h105});
    alu_q.push_back('{r: 5'd20, d: 32'h80000009});
    tick();
    alu_valid = 1'b0; lng_valid = 1'b0;
    repeat (8) tick();
    chk("full_alu_q_drained", 32'(alu_q.size()), 32'd0);
    chk("full_lng_q_drained", 32'(lng_q.size()), 32'd0);

    // Set/clear collision on r7, with an r0 reservation ignored
    rsv_valid = 1'b1; rsv_reg = 5'd7;
    tick();
    rsv_valid = 1'b0;
    lng_valid = 1'b1; lng_reg = 5'd7; lng_data = 32'h77;
    lng_q.push_back('{r: 5'd7, d: 32'h77});
    tick();
    lng_valid = 1'b0;
    rsv_valid = 1'b1; rsv_reg = 5'd7;
    tick();
    chk("coll_pop_we", 32'(we), 32'd1);
    chk("coll_busy7", 32'(busy[7]), 32'd1);
    rsv_reg = 5'd0;
    tick();
    rsv_valid = 1'b0;
    chk("coll_busy7_hold", 32'(busy[7]), 32'd1);
    chk("busy0_zero", 32'(busy[0]), 32'd0);
    lng_valid = 1'b1; lng_reg = 5'd7; lng_data = 32'h78;
    lng_q.push_back('{r: 5'd7, d: 32'h78});
    tick();
    lng_valid = 1'b0;
    tick();
    chk("coll_busy7_clear", 32'(busy[7]), 32'd0);

    // Reset in the middle of a stream
    rsv_valid = 1'b1; rsv_reg = 5'd11;
    tick();
    rsv_valid = 1'b0;
    chk("mid_busy11", 32'(busy[11]), 32'd1);
    alu_valid = 1'b1; alu_reg = 5'd21;
    for (int i = 0; i < 3; i++) begin
      alu_data = 32'h90000000 | 32'(i);
      alu_q.push_back('{r: 5'd21, d: alu_data});
      lng_valid = 1'b1; lng_reg = 5'(12 + i); lng_data = 32'h300 + 32'(i);
      lng_q.push_back('{r: lng_reg, d: lng_data});
      tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_ready", 32'(lng_ready), 32'd1);
    lng_q.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_we", 32'(we), 32'd0);
    end
    chk("mid_busy_after", busy, 32'd0);
    alu_valid = 1'b1; alu_reg = 5'd22; alu_data = 32'h900000AA;
    alu_q.push_back('{r: 5'd22, d: 32'h900000AA});
    tick();
    alu_valid = 1'b0;
    chk("mid_new_we", 32'(we), 32'd1);
    tick();
    chk("mid_final_we", 32'(we), 32'd0);
    chk("end_alu_q", 32'(alu_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
